// File: rtl/krz_gpio_pkg.sv
// Shared command encoding for the KRZ GPIO output driver.
package krz_gpio_pkg;

  typedef enum logic [1:0] {
    GPIO_OUT   = 2'd0,
    GPIO_SET   = 2'd1,
    GPIO_CLR   = 2'd2,
    GPIO_PULSE = 2'd3
  } gpio_cmd_e;

endpackage

// File: rtl/krz_gpio_pulse.sv
// One output channel's pulse counter: load/clear from the bus, count down on ticks,
// flag the cycle the pulse ends so the top can release the pin.
module krz_gpio_pulse #(
  parameter int PULSE_LEN = 8
) (
  input  logic clk,
  input  logic rstz,
  input  logic load_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic expire_o,
  output logic busy_o
);

  localparam int PW = $clog2(PULSE_LEN + 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = PW'(PULSE_LEN);
    else if (clr_i)                 cnt_d = '0;
    else if (tick_i && cnt_q != '0) cnt_d = cnt_q - PW'(1);
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A write to this channel in the tick cycle takes precedence over expiry.
  assign expire_o = tick_i & ~load_i & ~clr_i & (cnt_q == PW'(1));
  assign busy_o   = |cnt_q;

endmodule

// File: rtl/krz_gpio_drive.sv
// Bus-written GPIO output register with set/clear/pulse commands and a shared
// prescaled tick that times per-channel pulses.
module krz_gpio_drive
  import krz_gpio_pkg::*;
#(
  parameter int             N         = 16,
  parameter int             PRESCALE  = 16,
  parameter int             PULSE_LEN = 8,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rstz,
  input  logic         wr_en,
  input  logic [1:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  output logic [N-1:0] read,
  output logic [N-1:0] pulse_busy,
  output logic [N-1:0] gpio_out
);

  localparam logic [PRESCALE:0] TMR_ONE = (PRESCALE+1)'(1);

  logic [PRESCALE:0] timer_q, timer_d;
  logic              tick;
  logic [N-1:0]      out_q, out_d, base;
  logic [N-1:0]      load, clr, expire;
  gpio_cmd_e         cmd;

  // Timer reaches 2^PRESCALE, raises tick for one cycle, then wraps to 0.
  assign tick    = timer_q[PRESCALE];
  assign timer_d = tick ? '0 : timer_q + TMR_ONE;
  assign cmd     = gpio_cmd_e'(wr_addr);
  assign base    = out_q & ~expire;

  always_comb begin
    load  = '0;
    clr   = '0;
    out_d = base;
    if (wr_en) begin
      case (cmd)
        GPIO_OUT: begin
          clr   = '1;
          out_d = wr_data;
        end
        GPIO_SET: begin
          clr   = wr_data;
          out_d = base | wr_data;
        end
        GPIO_CLR: begin
          clr   = wr_data;
          out_d = base & ~wr_data;
        end
        GPIO_PULSE: begin
          load  = wr_data;
          out_d = base | wr_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      timer_q <= '0;
      out_q   <= RESET_VAL;
    end else begin
      timer_q <= timer_d;
      out_q   <= out_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    krz_gpio_pulse #(.PULSE_LEN(PULSE_LEN)) u_pulse (
      .clk      (clk),
      .rstz     (rstz),
      .load_i   (load[i]),
      .clr_i    (clr[i]),
      .tick_i   (tick),
      .expire_o (expire[i]),
      .busy_o   (pulse_busy[i])
    );
  end

  assign read     = out_q;
  assign gpio_out = out_q;

endmodule

// File: tb/tb_krz_gpio_drive.sv
// Directed bench for krz_gpio_drive: PRESCALE=2 (tick every 5 cycles), PULSE_LEN=3.
module tb_krz_gpio_drive;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rstz;
  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic [N-1:0] read, pulse_busy, gpio_out;

  int n_cmp = 0;
  int n_err = 0;
  int ecount;

  always #5 clk = ~clk;

  krz_gpio_drive #(
    .N(N), .PRESCALE(2), .PULSE_LEN(3), .RESET_VAL(16'h0000)
  ) dut (
    .clk(clk), .rstz(rstz), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .read(read), .pulse_busy(pulse_busy), .gpio_out(gpio_out)
  );

  // Edges since reset release; the timer is at (ecount % 5), tick edges are multiples of 5.
  always @(posedge clk or negedge rstz)
    if (!rstz) ecount <= 0;
    else       ecount <= ecount + 1;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] eo, input logic [N-1:0] eb);
    chk({tag, ".gpio"}, gpio_out, eo);
    chk({tag, ".read"}, read, eo);
    chk({tag, ".busy"}, pulse_busy, eb);
  endtask

  // Called at a negedge; the command is sampled at the next posedge, returns at the following negedge.
  task automatic cmd(input logic [1:0] a, input logic [N-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = '0;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Stop at a negedge where the timer reads 0, so the next write lands at timer=1.
  task automatic align();
    for (int i = 0; i < 6 && (ecount % 5) != 0; i++) @(negedge clk);
  endtask

  initial begin
    rstz = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = '0;
    wait_cyc(3);
    chk_all("por", 16'h0000, 16'h0000);
    rstz = 1'b1;

    // Plain register commands
    cmd(2'd0, 16'hA5A5); chk_all("out",  16'hA5A5, 16'h0000);
    cmd(2'd1, 16'h000F); chk_all("set",  16'hA5AF, 16'h0000);
    cmd(2'd2, 16'h0101); chk_all("clr",  16'hA4AE, 16'h0000);
    // wr_en low: data on the bus is ignored
    wr_addr = 2'd0; wr_data = 16'hFFFF; wait_cyc(1); wr_data = '0;
    chk_all("idle", 16'hA4AE, 16'h0000);

    // Single pulse: write edge k+1, ticks k+5,k+10,k+15 -> low after k+15
    cmd(2'd0, 16'h0000);
    align();
    cmd(2'd3, 16'h0002); chk_all("pulse.start", 16'h0002, 16'h0002);
    wait_cyc(13);        chk_all("pulse.last",  16'h0002, 16'h0002);
    wait_cyc(1);         chk_all("pulse.end",   16'h0000, 16'h0000);

    // Retrigger one tick in: reload at k+6, ends after k+20 instead of k+15
    align();
    cmd(2'd3, 16'h0002);
    wait_cyc(4);
    cmd(2'd3, 16'h0002); chk_all("retrig.start", 16'h0002, 16'h0002);
    wait_cyc(9);         chk_all("retrig.k15",   16'h0002, 16'h0002);
    wait_cyc(4);         chk_all("retrig.last",  16'h0002, 16'h0002);
    wait_cyc(1);         chk_all("retrig.end",   16'h0000, 16'h0000);

    // Cancel bit0 of a two-bit pulse; bit1 runs to completion
    align();
    cmd(2'd3, 16'h0003); chk_all("cancel.start", 16'h0003, 16'h0003);
    cmd(2'd2, 16'h0001); chk_all("cancel.clr",   16'h0002, 16'h0002);
    wait_cyc(12);        chk_all("cancel.last",  16'h0002, 16'h0002);
    wait_cyc(1);         chk_all("cancel.end",   16'h0000, 16'h0000);

    // SET landing on the expiring tick: write wins, pin held, counter cleared
    align();
    cmd(2'd3, 16'h0004);
    wait_cyc(13);        chk_all("coll.pre",  16'h0004, 16'h0004);
    cmd(2'd1, 16'h0004); chk_all("coll.set",  16'h0004, 16'h0000);
    wait_cyc(6);         chk_all("coll.hold", 16'h0004, 16'h0000);

    // Reset mid-pulse, then the timer must restart from 0
    cmd(2'd0, 16'h0000);
    align();
    cmd(2'd3, 16'h0020);
    wait_cyc(3);
    #2 rstz = 1'b0;
    #1 chk_all("rst.async", 16'h0000, 16'h0000);
    @(negedge clk);
    chk_all("rst.held", 16'h0000, 16'h0000);
    rstz = 1'b1;
    cmd(2'd3, 16'h0001); chk_all("rst.pulse", 16'h0001, 16'h0001);
    wait_cyc(13);        chk_all("rst.last",  16'h0001, 16'h0001);
    wait_cyc(1);         chk_all("rst.end",   16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
